// File: rtl/pled_switch_reader.sv
// Two-switch front panel reader: synchronize, debounce, classify presses.
// Short/long events step the LED pattern/level and toggle the fan.
//
// Ports (pled_switch_reader):
//   clkout_10m  in   10 MHz clock, rising edge
//   reset       in   synchronous, active-low
//   switch1/2   in   raw push switches, active-low (0 = pressed)
//   pattern     out  [1:0] color-pattern select
//   level       out  [2:0] brightness level
//   fan_en      out  fan enable
//   short1/long1/short2/long2  out  one-cycle press events
//   changed     out  one-cycle pulse when pattern/level/fan_en update
//
// Ports (pled_sw_chan): clkout_10m, reset, sw_i (raw), short_o, long_o

module pled_sw_chan #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int LONG_CYCLES     = 10000000
) (
  input  logic clkout_10m,
  input  logic reset,
  input  logic sw_i,
  output logic short_o,
  output logic long_o
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LONG_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HELD  = 2'd2
  } state_e;

  logic [1:0]    sync_q;
  logic          deb_q, deb_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  state_e        state_q, state_d;
  logic [LW-1:0] hold_q, hold_d;
  logic          pressed;

  assign pressed = ~deb_q;

  always_ff @(posedge clkout_10m) begin
    if (!reset) begin
      sync_q  <= 2'b11;
      deb_q   <= 1'b1;
      dcnt_q  <= '0;
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      sync_q  <= {sync_q[0], sw_i};
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Accept the new level on the edge the count would reach the limit.
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    if (sync_q[1] != deb_q) begin
      if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1))
        deb_d = sync_q[1];
      else
        dcnt_d = dcnt_q + DW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d = PRESS;
          hold_d  = '0;
        end
      end
      PRESS: begin
        if (!pressed) begin
          state_d = IDLE;
        end else begin
          if (hold_q != LW'(LONG_CYCLES))
            hold_d = hold_q + LW'(1);
          if (hold_q == LW'(LONG_CYCLES - 1))
            state_d = HELD;
        end
      end
      HELD: begin
        if (!pressed)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Events fire in the cycle the decision is taken; long uses the
  // cycle whose edge brings the hold count up to LONG_CYCLES.
  always_comb begin
    short_o = 1'b0;
    long_o  = 1'b0;
    if (state_q == PRESS) begin
      short_o = ~pressed;
      long_o  = pressed &&
                (hold_q == LW'(LONG_CYCLES - 1));
    end
  end
endmodule

module pled_switch_reader #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int LONG_CYCLES     = 10000000
) (
  input  logic       clkout_10m,
  input  logic       reset,
  input  logic       switch1,
  input  logic       switch2,
  output logic [1:0] pattern,
  output logic [2:0] level,
  output logic       fan_en,
  output logic       short1,
  output logic       long1,
  output logic       short2,
  output logic       long2,
  output logic       changed
);
  logic [1:0] pattern_q, pattern_d;
  logic [2:0] level_q, level_d;
  logic       fan_q, fan_d;
  logic       changed_q, changed_d;

  pled_sw_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LONG_CYCLES    (LONG_CYCLES)
  ) u_ch1 (
    .clkout_10m(clkout_10m),
    .reset     (reset),
    .sw_i      (switch1),
    .short_o   (short1),
    .long_o    (long1)
  );

  pled_sw_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LONG_CYCLES    (LONG_CYCLES)
  ) u_ch2 (
    .clkout_10m(clkout_10m),
    .reset     (reset),
    .sw_i      (switch2),
    .short_o   (short2),
    .long_o    (long2)
  );

  always_ff @(posedge clkout_10m) begin
    if (!reset) begin
      pattern_q <= 2'd0;
      level_q   <= 3'd7;
      fan_q     <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      level_q   <= level_d;
      fan_q     <= fan_d;
      changed_q <= changed_d;
    end
  end

  always_comb begin
    pattern_d = pattern_q;
    level_d   = level_q;
    fan_d     = fan_q;
    if (short1) pattern_d = pattern_q + 2'd1;
    if (long1)  pattern_d = 2'd0;
    if (short2) level_d   = level_q + 3'd1;
    if (long2)  fan_d     = ~fan_q;
    changed_d = short1 | long1 | short2 | long2;
  end

  assign pattern = pattern_q;
  assign level   = level_q;
  assign fan_en  = fan_q;
  assign changed = changed_q;
endmodule

// File: tb/tb_pled_switch_reader.sv
// Bench for pled_switch_reader: directed presses, scoreboarded events.
// Expected events carry their cycle, strobes and post-update outputs.

module tb_pled_switch_reader;
  localparam int DEB = 4;
  localparam int LNG = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw1 = 1'b1;
  logic       sw2 = 1'b1;
  logic [1:0] pattern;
  logic [2:0] level;
  logic       fan_en;
  logic       short1, long1, short2, long2;
  logic       changed;

  pled_switch_reader #(
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LNG)
  ) dut (
    .clkout_10m(clk),
    .reset     (rst_n),
    .switch1   (sw1),
    .switch2   (sw2),
    .pattern   (pattern),
    .level     (level),
    .fan_en    (fan_en),
    .short1    (short1),
    .long1     (long1),
    .short2    (short2),
    .long2     (long2),
    .changed   (changed)
  );

  always #50 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] strb;
    logic       chg;
    logic [1:0] pat;
    logic [2:0] lvl;
    logic       fan;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  logic [1:0] m_pat = 2'd0;
  logic [2:0] m_lvl = 3'd7;
  logic       m_fan = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if ((|{short1, long1, short2, long2}) || changed) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event cyc=%0d got strb=%b chg=%b want none",
                   cyc, {short1, long1, short2, long2}, changed);
        end else begin
          e = q.pop_front();
          if (cyc != e.cyc ||
              {short1, long1, short2, long2} != e.strb ||
              changed != e.chg || pattern != e.pat ||
              level != e.lvl || fan_en != e.fan) begin
            failures++;
            $display("FAIL event got cyc=%0d strb=%b chg=%b pat=%0d lvl=%0d fan=%b want cyc=%0d strb=%b chg=%b pat=%0d lvl=%0d fan=%b",
                     cyc, {short1, long1, short2, long2}, changed,
                     pattern, level, fan_en, e.cyc, e.strb, e.chg,
                     e.pat, e.lvl, e.fan);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Strobe cycle c shows old outputs; cycle c+1 shows the update.
  task automatic push_ev(input int c, input logic [3:0] s);
    q.push_back('{c, s, 1'b0, m_pat, m_lvl, m_fan});
    if (s[3]) m_pat = m_pat + 2'd1;
    if (s[2]) m_pat = 2'd0;
    if (s[1]) m_lvl = m_lvl + 3'd1;
    if (s[0]) m_fan = ~m_fan;
    q.push_back('{c + 1, 4'b0000, 1'b1, m_pat, m_lvl, m_fan});
  endtask

  // Raw edge at cycle p: debounced at p+6, long at p+6+LNG,
  // short at release+6 when release-press <= LNG.
  task automatic press(input int which, input int dur);
    int p;
    p = cyc;
    if (which == 1) sw1 = 1'b0;
    else            sw2 = 1'b0;
    if (dur > LNG)
      push_ev(p + 2 + DEB + LNG, which == 1 ? 4'b0100 : 4'b0001);
    step(dur);
    if (which == 1) sw1 = 1'b1;
    else            sw2 = 1'b1;
    if (dur <= LNG)
      push_ev(cyc + 2 + DEB, which == 1 ? 4'b1000 : 4'b0010);
    step(12);
  endtask

  task automatic chk_outs(input string name);
    chk({name, "_pattern"}, int'(pattern), int'(m_pat));
    chk({name, "_level"}, int'(level), int'(m_lvl));
    chk({name, "_fan"}, int'(fan_en), int'(m_fan));
  endtask

  initial begin : main
    logic seen;
    step(3);
    chk("rst_outs", int'({pattern, level, fan_en}), int'({2'd0, 3'd7, 1'b0}));
    chk("rst_strobes", int'({short1, long1, short2, long2, changed}), 0);
    rst_n = 1'b1;
    step(1);
    chk("post_rst_outs", int'({pattern, level, fan_en, changed}),
        int'({2'd0, 3'd7, 2'b00}));
    step(5);

    press(1, 10);
    chk_outs("short1_once");
    press(1, 6);
    press(1, 8);
    press(1, 5);
    chk("pattern_wrap", int'(pattern), 0);

    press(2, 40);
    chk("fan_on", int'(fan_en), 1);

    seen = 1'b0;
    sw1 = 1'b0;
    repeat (3) begin
      step(1);
      seen |= ~dut.u_ch1.deb_q;
    end
    sw1 = 1'b1;
    repeat (12) begin
      step(1);
      seen |= ~dut.u_ch1.deb_q;
    end
    chk("glitch_deb", int'(seen), 0);
    chk_outs("glitch");

    begin : both
      sw1 = 1'b0;
      sw2 = 1'b0;
      step(8);
      sw1 = 1'b1;
      sw2 = 1'b1;
      push_ev(cyc + 2 + DEB, 4'b1010);
      step(12);
    end
    chk("both_pattern", int'(pattern), 1);
    chk("both_level", int'(level), 0);

    press(1, 30);
    chk("long1_pattern", int'(pattern), 0);
    press(2, LNG);
    chk("edge_short_lvl", int'(level), 1);
    press(2, LNG + 1);
    chk("edge_long_fan", int'(fan_en), 0);
    press(1, 5);

    sw2 = 1'b0;
    step(15);
    rst_n = 1'b0;
    step(1);
    sw2 = 1'b1;
    step(4);
    rst_n = 1'b1;
    m_pat = 2'd0;
    m_lvl = 3'd7;
    m_fan = 1'b0;
    step(40);
    chk_outs("rst_midpress");

    rst_n = 1'b0;
    sw1 = 1'b0;
    step(3);
    rst_n = 1'b1;
    push_ev(cyc + 8 + 2 + DEB, 4'b1000);
    step(1);
    chk("held_rel_first", int'({pattern, level, changed}),
        int'({2'd0, 3'd7, 1'b0}));
    step(7);
    sw1 = 1'b1;
    step(14);
    chk("held_rel_press", int'(pattern), 1);

    step(10);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pled_switch_reader.md
PLED_SWITCH_READER -- requirements
Module: pled_switch_reader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 100000, consecutive stable cycles needed to accept a switch level change (10 ms at 10 MHz).
REQ-002 Parameter LONG_CYCLES, default 10000000, cycles a debounced press must last to count as a long press (1 s at 10 MHz).
REQ-003 clkout_10m  input  1  clock, 10 MHz, all logic on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 switch1  input  1  raw asynchronous push switch, active-low (0 = pressed).
REQ-006 switch2  input  1  raw asynchronous push switch, active-low (0 = pressed).
REQ-007 pattern  output  2  color-pattern select for the LED driver.
REQ-008 level  output  3  brightness level for the LED driver.
REQ-009 fan_en  output  1  fan enable.
REQ-010 short1, long1, short2, long2  output  1 each  one-cycle event strobes.
REQ-011 changed  output  1  one-cycle strobe, high on any cycle where pattern, level or fan_en is updated.

Function
REQ-012 Each switch input passes through a 2-flop synchronizer before any other use.
REQ-013 Debounce per switch: counter clears whenever the synchronized value equals the debounced value, otherwise increments.
- Debounced value takes the synchronized value on the edge where the counter would reach DEBOUNCE_CYCLES; counter clears on that edge.
- Counter width holds DEBOUNCE_CYCLES without overflow.
REQ-014 Latency: a clean raw edge shows on the debounced value exactly 2 + DEBOUNCE_CYCLES cycles later.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no change.
REQ-015 Each switch has its own FSM with states IDLE, PRESS, HELD, driven by the debounced, active-high "pressed" value.
REQ-016 IDLE -> PRESS on pressed; hold counter cleared.
REQ-017 PRESS: hold counter increments each cycle.
- Release before the count reaches LONG_CYCLES -> IDLE, with a short strobe in the cycle after release is seen.
- Count reaching LONG_CYCLES while still pressed -> HELD, with a long strobe in that cycle.
REQ-018 HELD -> IDLE on release with no strobe; exactly one event per press.
REQ-019 Hold counter saturates and never wraps; width holds LONG_CYCLES.
REQ-020 short1: pattern <= pattern + 1, wrapping 3 -> 0.
REQ-021 long1: pattern <= 0.
REQ-022 short2: level <= level + 1, wrapping 7 -> 0.
REQ-023 long2: fan_en <= ~fan_en.
REQ-024 Register updates take effect one cycle after the strobe; changed is asserted in that same update cycle.
REQ-025 Events on both switches in the same cycle are independent and both are applied; changed is asserted once.
REQ-026 Strobes are mutually exclusive per switch and each lasts exactly one cycle.

Reset
REQ-027 While reset = 0 at a clock edge:
- synchronizer and debounced values = 1 (released), counters = 0, both FSMs = IDLE;
- pattern = 0, level = 7, fan_en = 0, all strobes and changed = 0.
REQ-028 Reset mid-press discards the press in progress; no strobe is emitted for it.
- A switch still held when reset releases must first be debounced as pressed, then produces a normal press.
REQ-029 No output changes during reset or in the first cycle after reset release.

Verification (bench uses DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-030 Press switch1 for 10 cycles, then release -> one short1 pulse; pattern goes 0 -> 1 one cycle later with changed=1; no long1.
REQ-031 Four short presses on switch1 -> pattern steps 1, 2, 3, 0.
REQ-032 Hold switch2 for 40 cycles -> long2 fires exactly once, 2+4+20 cycles after press; fan_en goes 0 -> 1; release gives no short2.
REQ-033 3-cycle low glitch on switch1 -> debounced value never changes; no strobes; outputs unchanged.
REQ-034 Short-press switch1 and switch2 with releases seen in the same cycle -> short1 and short2 in the same cycle; pattern=1, level=0 (wrap from 7); single changed pulse.
REQ-035 Assert reset while switch2 has been held 15 cycles, release reset with switch2 released -> no strobes; level=7, fan_en=0.
